// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the serial BCD adder/subtractor.
// State enum, digit width and per-digit utility functions.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [BCD_W-1:0] nines_comp(
    input logic [BCD_W-1:0] digit
  );
    return 4'd9 - digit;
  endfunction

  function automatic logic digit_valid(
    input logic [BCD_W-1:0] digit
  );
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal (+6) correction.
// Purely combinational; chained by the top for multi-digit groups.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] bin;
  logic [BCD_W:0] fix;

  always_comb begin
    bin  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    fix  = bin + 5'd6;
    cout = bin > 5'd9;
    sum  = cout ? fix[BCD_W-1:0] : bin[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract: DPC digits per cycle, LSD first.
// Subtract uses the 9's complement of B with the carry seeded by Sub.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int N   = 3,
  parameter int DPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N-1:0]   A_in,
  input  logic [4*N-1:0]   B_in,
  input  logic             Cin_in,
  input  logic             Sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*N-1:0]   Sum_out,
  output logic             Cout_out,
  output logic             Err_out
);

  localparam int W     = BCD_W * N;
  localparam int GW    = BCD_W * DPC;
  localparam int STEPS = N / DPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, b_q, acc_q;
  logic [W-1:0]  b_cap, acc_next;
  logic          carry_q, err_q, in_err;
  logic [CW-1:0] cnt_q;
  logic          accept, last;

  logic [DPC:0]  c;
  logic [GW-1:0] grp_sum;

  assign accept = in_valid && in_ready;
  assign last   = cnt_q == CW'(STEPS - 1);

  always_comb begin
    b_cap  = '0;
    in_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      b_cap[i*BCD_W +: BCD_W] = Sub_in
        ? nines_comp(B_in[i*BCD_W +: BCD_W])
        : B_in[i*BCD_W +: BCD_W];
      in_err = in_err
        | !digit_valid(A_in[i*BCD_W +: BCD_W])
        | !digit_valid(B_in[i*BCD_W +: BCD_W]);
    end
  end

  assign c[0] = carry_q;

  for (genvar g = 0; g < DPC; g++) begin : g_dig
    bcd_digit_adder u_add (
      .a    (a_q[g*BCD_W +: BCD_W]),
      .b    (b_q[g*BCD_W +: BCD_W]),
      .cin  (c[g]),
      .sum  (grp_sum[g*BCD_W +: BCD_W]),
      .cout (c[g+1])
    );
  end

  // New digits enter at the top so the LSD group ends up at bit 0.
  assign acc_next = W'({grp_sum, acc_q} >> GW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      Sum_out  <= '0;
      Cout_out <= 1'b0;
      Err_out  <= 1'b0;
    end else if (accept) begin
      a_q     <= A_in;
      b_q     <= b_cap;
      acc_q   <= '0;
      carry_q <= Cin_in ^ Sub_in;
      err_q   <= in_err;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> GW;
      b_q     <= b_q >> GW;
      acc_q   <= acc_next;
      carry_q <= c[DPC];
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        Sum_out  <= err_q ? '0 : acc_next;
        Cout_out <= !err_q && c[DPC];
        Err_out  <= err_q;
      end
    end
  end

endmodule

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 SHALL have parameter N, default 3: number of BCD digits per operand; N >= 1.
REQ-002 SHALL have parameter DPC, default 1: digits processed per cycle; N % DPC == 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-007 SHALL have ports A_in and B_in, input, 4*N bits each: BCD operands, digit i at bits [4i+3:4i].
REQ-008 SHALL have port Cin_in, input, 1 bit: carry-in (add mode) or borrow-in (subtract mode).
REQ-009 SHALL have port Sub_in, input, 1 bit: 0 selects A+B+Cin, 1 selects A-B-Cin.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port Sum_out, output, 4*N bits: BCD result modulo 10^N.
REQ-013 SHALL have port Cout_out, output, 1 bit: decimal carry out of the top digit.
REQ-014 SHALL have port Err_out, output, 1 bit: an input digit was > 9.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE; in_ready = (state == IDLE).
REQ-016 SHALL accept operands on the edge where in_valid && in_ready: capture A, B (B replaced by its 9's complement if Sub_in = 1), carry = Cin_in XOR Sub_in, and clear the digit counter; then go to RUN.
REQ-017 In RUN, each cycle SHALL add DPC digits (LSD group first) through chained digit adders, store those result digits, and propagate the carry register.
REQ-018 After N/DPC RUN cycles SHALL enter DONE, with out_valid = 1 and Cout_out = final carry; latency from the accept edge to out_valid high = N/DPC cycles.
REQ-019 In subtract mode, Cout_out = 1 SHALL mean A >= B+Cin; Cout_out = 0 SHALL mean underflow, with Sum_out holding the 10's-complement wrap (10^N + A - B - Cin).
REQ-020 In DONE, Sum_out, Cout_out and Err_out SHALL be held stable until out_valid && out_ready; on that edge the block SHALL return to IDLE (in_ready high next cycle).
REQ-021 Any A or B digit > 9 at acceptance SHALL set Err_out = 1 in DONE and force Sum_out = 0 and Cout_out = 0; it still takes N/DPC cycles.
REQ-022 Inputs while in_ready = 0 SHALL be ignored; no operand set is ever dropped once accepted.
REQ-023 Outside DONE, out_valid SHALL be 0; Sum_out, Cout_out and Err_out keep their last values.

Reset
REQ-024 rst high SHALL immediately force state IDLE and set out_valid, Sum_out, Cout_out, Err_out, the carry register and the digit counter to 0, aborting any operation in progress.
REQ-025 Operands presented while rst is high SHALL not be accepted; the first acceptance can occur on the first rising edge after rst falls.

Structure
REQ-026 Package bcd_pkg SHALL hold the state enum, the constant BCD_W = 4, and functions nines_comp(digit) and digit_valid(digit).
REQ-027 SHALL instantiate DPC copies of sub-module bcd_digit_adder: 4-bit a, 4-bit b, cin -> 4-bit sum, cout, with +6 correction when the binary sum > 9.

Verification (N=3, DPC=1 unless stated)
REQ-028 999 + 001, Sub 0, Cin 0 -> Sum 000, Cout 1, out_valid exactly 3 cycles after accept.
REQ-029 123 - 045, Sub 1, Cin 0 -> 078, Cout 1; 045 - 123 -> 922, Cout 0; 500 - 499, Cin 1 -> 000, Cout 1.
REQ-030 A = 0x00A, B = 001 -> Err 1, Sum 000, Cout 0, after 3 cycles.
REQ-031 Hold out_ready low 5 cycles in DONE -> outputs constant, in_ready 0, a new in_valid not accepted; release -> IDLE the next cycle.
REQ-032 Assert rst during the second RUN cycle -> out_valid never rises; the next operation 111 + 222 -> 333 correctly.
REQ-033 Exhaustive random run with N=4, DPC=2, both modes -> matches the integer model, latency 2.
